// File: rtl/bus_bridge_periph_pkg.sv
// Shared constants for the CPU bus responder: peripheral register offsets,
// default peripheral window base, register decode and 7-segment glyphs.
package bus_bridge_periph_pkg;

   // Lowest byte address that belongs to the peripheral window.
   localparam logic [31:0] PERIPH_BASE_DEFAULT = 32'hFFFF_F000;

   // Word-aligned byte offsets from the peripheral base.
   localparam logic [31:0] OFF_DIG   = 32'h0000_0000;
   localparam logic [31:0] OFF_TIMER = 32'h0000_0020;
   localparam logic [31:0] OFF_LED   = 32'h0000_0060;
   localparam logic [31:0] OFF_SW    = 32'h0000_0070;
   localparam logic [31:0] OFF_BTN   = 32'h0000_0078;

   typedef enum logic [2:0] {
      REG_NONE,
      REG_DIG,
      REG_TIMER,
      REG_LED,
      REG_SW,
      REG_BTN
   } periph_reg_e;

   // Active-low {dp,g,f,e,d,c,b,a} glyphs; entry n is the glyph for hex digit n.
   localparam logic [15:0][7:0] SEG_GLYPHS = {
      8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
      8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
   };

   function automatic logic [7:0] seg7_glyph(input logic [3:0] nib);
      return SEG_GLYPHS[nib];
   endfunction

   // Map a word-aligned offset inside the peripheral window to a register.
   function automatic periph_reg_e decode_periph(input logic [31:0] off);
      periph_reg_e sel;
      case (off)
         OFF_DIG:   sel = REG_DIG;
         OFF_TIMER: sel = REG_TIMER;
         OFF_LED:   sel = REG_LED;
         OFF_SW:    sel = REG_SW;
         OFF_BTN:   sel = REG_BTN;
         default:   sel = REG_NONE;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/bus_bridge_periph_seg7_scan.sv
// Multiplexed 8-digit 7-segment scanner: a prescaler sets the dwell time of
// each digit slot, the digit index walks 0..7, and the glyph for the nibble
// of the active digit is shown. seg follows the digit value combinationally
// so a new value appears within the current slot.
module seg7_scan
   import bus_bridge_periph_pkg::*;
#(
   parameter int SCAN_DIV = 20000
) (
   input  logic        cpu_clk,
   input  logic        cpu_rst,
   input  logic [31:0] digits,
   output logic [7:0]  dig_en,
   output logic [7:0]  seg
);

   localparam int PW = $clog2(SCAN_DIV);
   localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

   logic [PW-1:0] presc_reg;
   logic [PW-1:0] presc_next;
   logic [2:0]    idx_reg;
   logic [2:0]    idx_next;
   logic [3:0]    nib [8];

   // Prescaler wraps at terminal count; the digit index steps on that cycle
   // and wraps 7 -> 0 through its natural 3-bit overflow.
   always_comb begin
      presc_next = presc_reg + 1'b1;
      idx_next   = idx_reg;
      if (presc_reg == PRESC_LAST) begin
         presc_next = '0;
         idx_next   = idx_reg + 3'd1;
      end
   end

   // Scan position registers.
   always_ff @(posedge cpu_clk or negedge cpu_rst) begin
      if (!cpu_rst) begin
         presc_reg <= '0;
         idx_reg   <= '0;
      end else begin
         presc_reg <= presc_next;
         idx_reg   <= idx_next;
      end
   end

   // Split the digit word into nibbles and build the active-low one-hot enable.
   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_digit
         assign nib[gi]    = digits[4*gi +: 4];
         assign dig_en[gi] = (idx_reg != 3'(gi));
      end
   endgenerate

   assign seg = seg7_glyph(nib[idx_reg]);

endmodule

// File: rtl/bus_bridge_periph.sv
// CPU data-bus responder: splits the address space into DRAM (below the
// peripheral base) and a small peripheral window holding the 7-seg digit
// register, a free-running timer, the LED register and synchronised
// switch/button inputs. Read data is combinational from the address.
module bus_bridge_periph
   import bus_bridge_periph_pkg::*;
#(
   parameter int          DRAM_AW     = 16,
   parameter int          SCAN_DIV    = 20000,
   parameter logic [31:0] PERIPH_BASE = PERIPH_BASE_DEFAULT
) (
   input  logic               cpu_clk,
   input  logic               cpu_rst,
   input  logic [31:0]        Bus_addr,
   input  logic [31:0]        Bus_wdata,
   input  logic               en_data_trans,
   output logic [31:0]        data_to_cpu,
   output logic [DRAM_AW-1:0] dram_addr,
   output logic [31:0]        dram_wdata,
   output logic               dram_we,
   input  logic [31:0]        dram_rdata,
   input  logic [23:0]        sw,
   input  logic [4:0]         button,
   output logic [23:0]        led,
   output logic [7:0]         dig_en,
   output logic [7:0]         seg
);

   logic        is_periph;
   logic [31:0] off_aligned;
   periph_reg_e reg_sel;
   logic        periph_wr;

   logic [23:0] led_reg, led_next;
   logic [31:0] dig_reg, dig_next;
   logic [31:0] timer_reg, timer_next;
   logic [23:0] sw_meta_reg, sw_sync_reg;
   logic [4:0]  btn_meta_reg, btn_sync_reg;
   logic [31:0] periph_rdata;

   // Address decode; the low two address bits are dropped everywhere.
   assign is_periph   = (Bus_addr >= PERIPH_BASE);
   assign off_aligned = (Bus_addr - PERIPH_BASE) & 32'hFFFF_FFFC;
   assign reg_sel     = is_periph ? decode_periph(off_aligned) : REG_NONE;
   assign periph_wr   = en_data_trans & is_periph;

   // DRAM side is a straight pass-through with the write gated by the decode.
   assign dram_addr  = Bus_addr[DRAM_AW+1:2];
   assign dram_wdata = Bus_wdata;
   assign dram_we    = en_data_trans & ~is_periph;

   // Next-state for the writable peripheral registers; a timer store wins over counting.
   always_comb begin
      led_next   = led_reg;
      dig_next   = dig_reg;
      timer_next = timer_reg + 32'd1;
      if (periph_wr) begin
         case (reg_sel)
            REG_LED:   led_next   = Bus_wdata[23:0];
            REG_DIG:   dig_next   = Bus_wdata;
            REG_TIMER: timer_next = Bus_wdata;
            default:   ;
         endcase
      end
   end

   // Peripheral state and two-flop input synchronisers.
   always_ff @(posedge cpu_clk or negedge cpu_rst) begin
      if (!cpu_rst) begin
         led_reg      <= '0;
         dig_reg      <= '0;
         timer_reg    <= '0;
         sw_meta_reg  <= '0;
         sw_sync_reg  <= '0;
         btn_meta_reg <= '0;
         btn_sync_reg <= '0;
      end else begin
         led_reg      <= led_next;
         dig_reg      <= dig_next;
         timer_reg    <= timer_next;
         sw_meta_reg  <= sw;
         sw_sync_reg  <= sw_meta_reg;
         btn_meta_reg <= button;
         btn_sync_reg <= btn_meta_reg;
      end
   end

   // Peripheral read mux; unmapped offsets read as zero.
   always_comb begin
      periph_rdata = '0;
      case (reg_sel)
         REG_DIG:   periph_rdata = dig_reg;
         REG_TIMER: periph_rdata = timer_reg;
         REG_LED:   periph_rdata = {8'b0, led_reg};
         REG_SW:    periph_rdata = {8'b0, sw_sync_reg};
         REG_BTN:   periph_rdata = {27'b0, btn_sync_reg};
         default:   periph_rdata = '0;
      endcase
   end

   assign data_to_cpu = is_periph ? periph_rdata : dram_rdata;
   assign led         = led_reg;

   seg7_scan #(
      .SCAN_DIV (SCAN_DIV)
   ) u_scan (
      .cpu_clk (cpu_clk),
      .cpu_rst (cpu_rst),
      .digits  (dig_reg),
      .dig_en  (dig_en),
      .seg     (seg)
   );

endmodule

// File: tb/tb_bus_bridge_periph.sv
// Self-checking bench for bus_bridge_periph: directed scenarios followed by
// randomized bus traffic, all compared against an abstract model of the
// register map, timer, synchronisers and scan position.
module tb_bus_bridge_periph;

   localparam int          SCAN_DIV = 4;
   localparam int          DRAM_AW  = 16;
   localparam logic [31:0] BASE     = 32'hFFFF_F000;

   logic               cpu_clk = 1'b0;
   logic               cpu_rst = 1'b0;
   logic [31:0]        Bus_addr = '0;
   logic [31:0]        Bus_wdata = '0;
   logic               en_data_trans = 1'b0;
   logic [31:0]        data_to_cpu;
   logic [DRAM_AW-1:0] dram_addr;
   logic [31:0]        dram_wdata;
   logic               dram_we;
   logic [31:0]        dram_rdata = '0;
   logic [23:0]        sw = '0;
   logic [4:0]         button = '0;
   logic [23:0]        led;
   logic [7:0]         dig_en;
   logic [7:0]         seg;

   bus_bridge_periph #(
      .DRAM_AW     (DRAM_AW),
      .SCAN_DIV    (SCAN_DIV),
      .PERIPH_BASE (BASE)
   ) dut (
      .cpu_clk       (cpu_clk),
      .cpu_rst       (cpu_rst),
      .Bus_addr      (Bus_addr),
      .Bus_wdata     (Bus_wdata),
      .en_data_trans (en_data_trans),
      .data_to_cpu   (data_to_cpu),
      .dram_addr     (dram_addr),
      .dram_wdata    (dram_wdata),
      .dram_we       (dram_we),
      .dram_rdata    (dram_rdata),
      .sw            (sw),
      .button        (button),
      .led           (led),
      .dig_en        (dig_en),
      .seg           (seg)
   );

   always #5 cpu_clk = ~cpu_clk;

   int n_checks = 0;
   int n_errors = 0;

   // Hex glyph table written out from the display definition.
   logic [7:0] glyph_tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                  8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
   logic [31:0] mapped_off [5] = '{32'h000, 32'h020, 32'h060, 32'h070, 32'h078};

   // Reference model state
   logic [23:0] m_led;
   logic [31:0] m_dig;
   logic [31:0] m_timer;
   logic [23:0] m_sw1, m_sw2;
   logic [4:0]  m_btn1, m_btn2;
   int          m_cycles;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_led = '0; m_dig = '0; m_timer = '0;
      m_sw1 = '0; m_sw2 = '0; m_btn1 = '0; m_btn2 = '0;
      m_cycles = 0;
   endtask

   // One clock edge of the abstract model, using the inputs held across the edge.
   task automatic model_edge();
      logic [31:0] off;
      logic        load_timer;
      if (!cpu_rst) begin
         model_reset();
      end else begin
         load_timer = 1'b0;
         if (en_data_trans && Bus_addr >= BASE) begin
            off = (Bus_addr - BASE) & 32'hFFFF_FFFC;
            if (off == 32'h000) m_dig = Bus_wdata;
            if (off == 32'h060) m_led = Bus_wdata[23:0];
            if (off == 32'h020) begin
               m_timer = Bus_wdata;
               load_timer = 1'b1;
            end
         end
         if (!load_timer) m_timer = m_timer + 32'd1;
         m_sw2 = m_sw1;   m_sw1 = sw;
         m_btn2 = m_btn1; m_btn1 = button;
         m_cycles++;
      end
   endtask

   function automatic logic [31:0] model_read(input logic [31:0] a);
      logic [31:0] off;
      if (a < BASE) return dram_rdata;
      off = (a - BASE) & 32'hFFFF_FFFC;
      case (off)
         32'h000: return m_dig;
         32'h020: return m_timer;
         32'h060: return {8'b0, m_led};
         32'h070: return {8'b0, m_sw2};
         32'h078: return {27'b0, m_btn2};
         default: return 32'h0;
      endcase
   endfunction

   function automatic int model_idx();
      return (m_cycles / SCAN_DIV) % 8;
   endfunction

   task automatic step();
      @(posedge cpu_clk);
      model_edge();
      #1;
   endtask

   task automatic check_all(input string tag);
      logic [7:0]  one_hot;
      logic [31:0] nib;
      int          idx;
      idx     = model_idx();
      one_hot = 8'h01 << idx;
      nib     = (m_dig >> (4 * idx)) & 32'hF;
      check_eq({tag, ".rdata"}, data_to_cpu, model_read(Bus_addr));
      check_eq({tag, ".we"}, {31'b0, dram_we}, {31'b0, en_data_trans & (Bus_addr < BASE)});
      check_eq({tag, ".daddr"}, {16'b0, dram_addr}, (Bus_addr >> 2) & 32'hFFFF);
      check_eq({tag, ".dwdata"}, dram_wdata, Bus_wdata);
      check_eq({tag, ".led"}, {8'b0, led}, {8'b0, m_led});
      check_eq({tag, ".dig_en"}, {24'b0, dig_en}, {24'b0, ~one_hot});
      check_eq({tag, ".seg"}, {24'b0, seg}, {24'b0, glyph_tbl[nib[3:0]]});
   endtask

   task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic we);
      Bus_addr = a; Bus_wdata = d; en_data_trans = we;
      #1;
   endtask

   initial begin
      logic [7:0] exp_en;
      model_reset();

      // Reset state, held over a couple of edges
      #1;
      check_eq("rst.led", {8'b0, led}, 32'h0);
      check_eq("rst.dig_en", {24'b0, dig_en}, 32'hFE);
      check_eq("rst.seg", {24'b0, seg}, 32'hC0);
      step(); step();
      cpu_rst = 1'b1;

      // 1: LED write then read-back
      drive(BASE + 32'h60, 32'h00A5_A5A5, 1'b1);
      check_eq("t1.we", {31'b0, dram_we}, 32'h0);
      step();
      drive(BASE + 32'h60, 32'h0, 1'b0);
      check_eq("t1.led", {8'b0, led}, 32'h00A5_A5A5);
      check_eq("t1.read", data_to_cpu, 32'h00A5_A5A5);
      check_all("t1");

      // 2: DRAM store and load
      drive(32'h0000_0010, 32'hDEAD_BEEF, 1'b1);
      check_eq("t2.we", {31'b0, dram_we}, 32'h1);
      check_eq("t2.daddr", {16'b0, dram_addr}, 32'h4);
      check_eq("t2.dwdata", dram_wdata, 32'hDEAD_BEEF);
      step();
      dram_rdata = 32'h1234;
      drive(32'h0000_0010, 32'h0, 1'b0);
      check_eq("t2.load", data_to_cpu, 32'h1234);

      // 3: switch and button synchronisers
      sw = 24'h00F00F; button = 5'b10001;
      drive(BASE + 32'h70, 32'h0, 1'b0);
      step();
      check_eq("t3.sw_1edge", data_to_cpu, 32'h0);
      step();
      check_eq("t3.sw_2edge", data_to_cpu, 32'h0000_F00F);
      drive(BASE + 32'h78, 32'h0, 1'b0);
      check_eq("t3.btn", data_to_cpu, 32'h11);

      // 4: timer load and wrap
      drive(BASE + 32'h20, 32'hFFFF_FFFE, 1'b1);
      step();
      drive(BASE + 32'h20, 32'h0, 1'b0);
      check_eq("t4.t0", data_to_cpu, 32'hFFFF_FFFE);
      step();
      check_eq("t4.t1", data_to_cpu, 32'hFFFF_FFFF);
      step();
      check_eq("t4.t2", data_to_cpu, 32'h0000_0000);

      // 5: scanning across more than one full rotation
      drive(BASE + 32'h0, 32'h7654_3210, 1'b1);
      step();
      drive(BASE + 32'h0, 32'h0, 1'b0);
      for (int c = 0; c < 40; c++) begin
         check_all("t5");
         exp_en = 8'h01 << model_idx();
         check_eq("t5.seg_digit", {24'b0, seg}, {24'b0, glyph_tbl[model_idx()]});
         check_eq("t5.en_const", {24'b0, dig_en}, {24'b0, ~exp_en});
         step();
      end

      // Randomized traffic
      for (int t = 0; t < 300; t++) begin
         int          op;
         logic [31:0] a, d;
         logic        we;
         op = $urandom_range(0, 6);
         d  = $urandom;
         we = 1'b0;
         case (op)
            0: begin a = BASE + 32'h60; we = 1'b1; end
            1: begin a = BASE + 32'h00; we = 1'b1; end
            2: begin a = BASE + 32'h20; we = 1'b1; end
            3: begin a = BASE + ($urandom_range(0, 1023) << 2); we = 1'b1; end
            4: begin a = $urandom & 32'h7FFF_FFFF; we = 1'b1; end
            5: a = BASE + mapped_off[$urandom_range(0, 4)];
            default: a = $urandom & 32'h7FFF_FFFF;
         endcase
         a = a | 32'($urandom_range(0, 3));
         if ($urandom_range(0, 3) == 0) sw = 24'($urandom);
         if ($urandom_range(0, 3) == 0) button = 5'($urandom);
         dram_rdata = $urandom;
         drive(a, d, we);
         $display("txn %0d op=%0d addr=%h wdata=%h we=%0d rdata=%h", t, op, a, d, we, data_to_cpu);
         check_all("rnd");
         step();
      end

      // 6: asynchronous reset mid-scan with nonzero state
      drive(BASE + 32'h60, 32'h0012_3456, 1'b1);
      step();
      drive(BASE + 32'h20, 32'h0, 1'b0);
      step(); step();
      check_eq("t6.led_pre", {8'b0, led}, 32'h0012_3456);
      cpu_rst = 1'b0;
      model_reset();
      #1;
      check_eq("t6.led", {8'b0, led}, 32'h0);
      check_eq("t6.timer", data_to_cpu, 32'h0);
      check_eq("t6.dig_en", {24'b0, dig_en}, 32'hFE);
      check_eq("t6.seg", {24'b0, seg}, 32'hC0);
      step();
      cpu_rst = 1'b1;
      step();
      check_eq("t6.timer_resume", data_to_cpu, 32'h1);
      check_all("t6");
      drive(BASE + 32'h40, 32'h0, 1'b0);
      check_eq("t6.unmapped", data_to_cpu, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
